// File: rtl/bus_mem_rw_pkg.sv
// Shared definitions for the bus_mem_rw RAM slave: FSM encoding, wait-counter
// width and the address decode helper.
package bus_mem_rw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int CNT_W = 4;

  function automatic logic addr_hit(input logic [31:0] a,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (a & mask) == base;
  endfunction

endpackage

// File: rtl/bus_mem_rw_ram_sp_be.sv
// Single-port 2**ADDR_W x 32 synchronous RAM with byte enables.
// Storage only, so it maps onto block RAM.
module ram_sp_be #(
  parameter int ADDR_W    = 10,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bus_mem_rw.sv
// PicoRV32 native-bus RAM slave: base/mask decode, request latches, wait-state
// counter and a three-state handshake FSM in front of ram_sp_be.
module bus_mem_rw
  import bus_mem_rw_pkg::*;
#(
  parameter int          MEM_WORDS_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h0010_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFFF0_0000,
  parameter int          WAIT_STATES    = 0,
  parameter bit          WRITABLE       = 1'b1,
  parameter              INIT_FILE      = "prog.mem"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata
);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MEM_WORDS_LOG2-1:0] idx_q, idx_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic [31:0]               rdata_q, rdata_d;

  logic        hit;
  logic        op_fire;
  logic        is_read;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  assign hit     = addr_hit(addr, BASE_ADDR, ADDR_MASK);
  assign is_read = (wstrb_q == 4'b0000);
  // The memory op is not gated by rst: a write whose op edge meets the reset
  // edge still lands, only the handshake is aborted.
  assign op_fire = (state_q == ST_WAIT) && (cnt_q == '0);
  assign ram_we  = (op_fire && WRITABLE) ? wstrb_q : 4'b0000;

  ram_sp_be #(
    .ADDR_W    (MEM_WORDS_LOG2),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (op_fire),
    .we    (ram_we),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (valid && hit) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(WAIT_STATES);
          idx_d   = addr[MEM_WORDS_LOG2+1:2];
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (is_read) rdata_d = ram_rdata;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready = (state_q == ST_RESP);
  // RAM output is live during RESP; rdata_q keeps it afterwards until the next read.
  assign rdata = (state_q == ST_RESP && is_read) ? ram_rdata : rdata_q;

endmodule

// File: tb/tb_bus_mem_rw.sv
// Scoreboard bench for bus_mem_rw: four instances cover WAIT_STATES 0/3/4 and
// ROM mode; read expectations are queued at issue and popped on ready.
module tb_bus_mem_rw;

  logic             clk;
  logic [3:0]       rst, valid, ready;
  logic [3:0][31:0] addr, wdata, rdata;
  logic [3:0][3:0]  wstrb;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  bus_mem_rw #(.WAIT_STATES(0), .WRITABLE(1'b1), .INIT_FILE("")) dut0 (
    .clk(clk), .rst(rst[0]), .valid(valid[0]), .ready(ready[0]), .addr(addr[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .rdata(rdata[0]));
  bus_mem_rw #(.WAIT_STATES(3), .WRITABLE(1'b1), .INIT_FILE("")) dut1 (
    .clk(clk), .rst(rst[1]), .valid(valid[1]), .ready(ready[1]), .addr(addr[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .rdata(rdata[1]));
  bus_mem_rw #(.WAIT_STATES(4), .WRITABLE(1'b1), .INIT_FILE("")) dut2 (
    .clk(clk), .rst(rst[2]), .valid(valid[2]), .ready(ready[2]), .addr(addr[2]),
    .wdata(wdata[2]), .wstrb(wstrb[2]), .rdata(rdata[2]));
  bus_mem_rw #(.WAIT_STATES(0), .WRITABLE(1'b0), .INIT_FILE("")) dut3 (
    .clk(clk), .rst(rst[3]), .valid(valid[3]), .ready(ready[3]), .addr(addr[3]),
    .wdata(wdata[3]), .wstrb(wstrb[3]), .rdata(rdata[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int d);
    case (d)
      1:       return 3;
      2:       return 4;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction; returns at the negedge after the ready cycle.
  task automatic bus_op(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] sb, input logic [31:0] exp_rd,
                        input bit cmp_rd, input bit hold, input string tag,
                        output logic [31:0] rd_got);
    int lat;
    logic [31:0] e;
    @(negedge clk);
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = sb;
    if (sb == 4'b0000 && cmp_rd) exp_q.push_back(exp_rd);
    lat = -1;
    rd_got = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1 && !hold) begin
        valid[d] = 1'b0; addr[d] = ~a; wdata[d] = ~wd; wstrb[d] = ~sb;
      end
      if (ready[d]) begin
        lat = n;
        rd_got = rdata[d];
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(ws_of(d) + 2));
    if (sb == 4'b0000 && cmp_rd && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, " rdata"}, rd_got, e);
    end
    @(negedge clk);
    check({tag, " ready width"}, {31'd0, ready[d]}, 32'd0);
    if (sb == 4'b0000 && cmp_rd) check({tag, " rdata held"}, rdata[d], rd_got);
  endtask

  initial begin
    logic [31:0] rd, snap;
    int cnt;
    rst = '1; valid = '0; addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check("reset ready", {31'd0, ready[d]}, 32'd0);
      check("reset rdata", rdata[d], 32'd0);
    end
    rst = '0;

    // Basic read, partial write and aliasing on the zero-wait instance
    bus_op(0, 32'h0010_0014, 32'hDEADBEEF, 4'hF, 0, 0, 0, "t1 wr", rd);
    bus_op(0, 32'h0010_0014, 32'h0, 4'h0, 32'hDEADBEEF, 1, 0, "t1 rd", rd);
    bus_op(0, 32'h0010_000C, 32'hAABBCCDD, 4'hF, 0, 0, 0, "t2 wr", rd);
    bus_op(0, 32'h0010_000C, 32'h11223344, 4'b0101, 0, 0, 0, "t2 pwr", rd);
    bus_op(0, 32'h0010_000C, 32'h0, 4'h0, 32'hAA22CC44, 1, 0, "t2 rd", rd);
    bus_op(0, 32'h0010_1008, 32'h5555AAAA, 4'hF, 0, 0, 0, "alias wr", rd);
    bus_op(0, 32'h0010_0008, 32'h0, 4'h0, 32'h5555AAAA, 1, 0, "alias rd", rd);

    // Miss: another slave owns the address
    bus_op(0, 32'h0010_0000, 32'h12345678, 4'hF, 0, 0, 0, "t3 wr", rd);
    @(negedge clk);
    valid[0] = 1'b1; addr[0] = 32'h0020_0000; wdata[0] = 32'hFFFFFFFF; wstrb[0] = 4'hF;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ready[0]) cnt++;
    end
    valid[0] = 1'b0;
    check("t3 miss ready count", 32'(cnt), 32'd0);
    bus_op(0, 32'h0010_0000, 32'h0, 4'h0, 32'h12345678, 1, 0, "t3 rd", rd);

    // Three wait states, valid held through ready
    bus_op(1, 32'h0010_001C, 32'hCAFEF00D, 4'hF, 0, 0, 0, "t4 wr", rd);
    exp_q.push_back(32'hCAFEF00D);
    bus_op(1, 32'h0010_001C, 32'h0, 4'h0, 32'hCAFEF00D, 1, 1, "t4 rd", rd);
    cnt = -1;
    for (int m = 1; m <= 20; m++) begin
      @(negedge clk);
      if (ready[1]) begin
        cnt = m;
        break;
      end
    end
    valid[1] = 1'b0;
    check("t4 reaccept gap", 32'(cnt), 32'd5);
    if (exp_q.size() > 0) check("t4 reaccept rdata", rdata[1], exp_q.pop_front());
    @(negedge clk);
    check("t4 second width", {31'd0, ready[1]}, 32'd0);

    // ROM mode: store acknowledged but discarded
    bus_op(3, 32'h0010_0000, 32'h0, 4'h0, 0, 0, 0, "t5 snap", snap);
    bus_op(3, 32'h0010_0000, 32'hFFFFFFFF, 4'hF, 0, 0, 0, "t5 wr", rd);
    bus_op(3, 32'h0010_0000, 32'h0, 4'h0, snap, 1, 0, "t5 rd", rd);
    check("t5 not written", {31'd0, rd == 32'hFFFFFFFF}, 32'd0);

    // Reset during WAIT aborts the transaction
    bus_op(2, 32'h0010_0000, 32'h0BADF00D, 4'hF, 0, 0, 0, "t6 wr", rd);
    bus_op(2, 32'h0010_0000, 32'h0, 4'h0, 32'h0BADF00D, 1, 0, "t6 rd0", rd);
    @(negedge clk);
    valid[2] = 1'b1; addr[2] = 32'h0010_0004; wstrb[2] = 4'h0;
    @(negedge clk);
    valid[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    check("t6 abort ready", {31'd0, ready[2]}, 32'd0);
    check("t6 abort rdata", rdata[2], 32'd0);
    rst[2] = 1'b0;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ready[2]) cnt++;
    end
    check("t6 no late ready", 32'(cnt), 32'd0);
    bus_op(2, 32'h0010_1000, 32'h0, 4'h0, 32'h0BADF00D, 1, 0, "t6 alias rd", rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
